// File: rtl/soc_system_button_debounce_if.sv
// Button debouncer signal bundle: raw pins and enable in, filtered level and strobes out.
// The master side owns the pins and enable; the slave side is the debouncer.
interface soc_system_button_debounce_if #(
    parameter int WIDTH = 2
);
    logic             enable;
    logic [WIDTH-1:0] button_raw;
    logic [WIDTH-1:0] button_debounced;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;

    modport master (
        output enable, button_raw,
        input  button_debounced, press_pulse, release_pulse
    );

    modport slave (
        input  enable, button_raw,
        output button_debounced, press_pulse, release_pulse
    );
endinterface

// File: rtl/soc_system_button_debounce.sv
// Per-channel push-button debouncer: a two-flop synchronizer, then a stable-count filter.
// All outputs are registered, so no input reaches an output combinationally.
module soc_system_button_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic raw,
    output logic debounced,
    output logic press,
    output logic rel
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {ST_STABLE, ST_QUALIFY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        if (!enable) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (sync2_q != stable_q) begin
                        state_d = ST_QUALIFY;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    // Any agreeing sample throws away the partial qualification.
                    if (sync2_q == stable_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d  = ST_STABLE;
                        cnt_d    = '0;
                        stable_d = sync2_q;
                        press_d  = ~sync2_q;
                        rel_d    = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
        end
    end

    assign debounced = stable_q;
    assign press     = press_q;
    assign rel       = rel_q;
endmodule

module soc_system_button_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    soc_system_button_debounce_if.slave   bus
);
    logic [WIDTH-1:0] db_lane;
    logic [WIDTH-1:0] press_lane;
    logic [WIDTH-1:0] rel_lane;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        soc_system_button_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .enable   (bus.enable),
            .raw      (bus.button_raw[i]),
            .debounced(db_lane[i]),
            .press    (press_lane[i]),
            .rel      (rel_lane[i])
        );
    end

    assign bus.button_debounced = db_lane;
    assign bus.press_pulse      = press_lane;
    assign bus.release_pulse    = rel_lane;
endmodule

// File: tb/tb_soc_system_button_debounce.sv
// Directed vector table for the button debouncer (WIDTH=2, DEBOUNCE_CYCLES=4),
// followed by a few hand-written latency and enable-hold sequences.
module tb_soc_system_button_debounce;
    localparam int W = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    soc_system_button_debounce_if #(.WIDTH(W)) bus ();

    soc_system_button_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic         rst_n;
        logic         en;
        logic [W-1:0] raw;
        logic [W-1:0] db;
        logic [W-1:0] pr;
        logic [W-1:0] rl;
        string        name;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic e, input logic [W-1:0] raw,
                       input logic [W-1:0] db, input logic [W-1:0] pr,
                       input logic [W-1:0] rl, input string name, input int rep);
        vec_t v;
        v.rst_n = r; v.en = e; v.raw = raw; v.db = db; v.pr = pr; v.rl = rl; v.name = name;
        for (int k = 0; k < rep; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Row k's inputs are sampled at edge k; its outputs are checked just after edge k.
        add(0, 1, 2'b11, 2'b11, 2'b00, 2'b00, "reset",       2);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, "idle",        18);
        add(1, 1, 2'b01, 2'b11, 2'b00, 2'b00, "glitch",      3);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, "glitch_end",  6);
        add(1, 1, 2'b10, 2'b11, 2'b00, 2'b00, "press_wait",  5);
        add(1, 1, 2'b10, 2'b10, 2'b01, 2'b00, "press_edge",  1);
        add(1, 1, 2'b10, 2'b10, 2'b00, 2'b00, "press_hold",  3);
        add(1, 1, 2'b11, 2'b10, 2'b00, 2'b00, "rel_wait",    5);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b01, "rel_edge",    1);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, "rel_hold",    3);
        add(1, 1, 2'b10, 2'b11, 2'b00, 2'b00, "bounce_lo",   2);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, "bounce_hi",   2);
        add(1, 1, 2'b10, 2'b11, 2'b00, 2'b00, "bounce_lo",   2);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, "bounce_hi",   2);
        add(1, 1, 2'b10, 2'b11, 2'b00, 2'b00, "settle_wait", 5);
        add(1, 1, 2'b10, 2'b10, 2'b01, 2'b00, "settle_edge", 1);
        add(1, 1, 2'b10, 2'b10, 2'b00, 2'b00, "settle_hold", 3);
        add(1, 1, 2'b01, 2'b10, 2'b00, 2'b00, "simul_wait",  5);
        add(1, 1, 2'b01, 2'b01, 2'b10, 2'b01, "simul_edge",  1);
        add(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, "simul_hold",  3);
        add(1, 1, 2'b11, 2'b01, 2'b00, 2'b00, "idle2_wait",  5);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b10, "idle2_edge",  1);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, "idle2_hold",  3);
        add(1, 1, 2'b10, 2'b11, 2'b00, 2'b00, "rstq_pre",    4);
        add(0, 1, 2'b10, 2'b11, 2'b00, 2'b00, "rstq_rst",    1);
        add(1, 1, 2'b10, 2'b11, 2'b00, 2'b00, "rstq_wait",   5);
        add(1, 1, 2'b10, 2'b10, 2'b01, 2'b00, "rstq_edge",   1);
        add(1, 1, 2'b10, 2'b10, 2'b00, 2'b00, "rstq_hold",   2);
        add(1, 1, 2'b11, 2'b10, 2'b00, 2'b00, "rel2_wait",   5);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b01, "rel2_edge",   1);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, "rel2_hold",   2);
        add(1, 1, 2'b10, 2'b11, 2'b00, 2'b00, "en_pre",      4);
        add(1, 0, 2'b10, 2'b11, 2'b00, 2'b00, "en_off",      3);
        add(1, 1, 2'b10, 2'b11, 2'b00, 2'b00, "en_wait",     3);
        add(1, 1, 2'b10, 2'b10, 2'b01, 2'b00, "en_edge",     1);
        add(1, 1, 2'b10, 2'b10, 2'b00, 2'b00, "en_hold",     2);

        reset_n        = 1'b0;
        bus.enable     = 1'b1;
        bus.button_raw = 2'b11;

        foreach (vecs[i]) begin
            reset_n        = vecs[i].rst_n;
            bus.enable     = vecs[i].en;
            bus.button_raw = vecs[i].raw;
            step();
            check({vecs[i].name, "_db"}, bus.button_debounced, vecs[i].db);
            check({vecs[i].name, "_press"}, bus.press_pulse, vecs[i].pr);
            check({vecs[i].name, "_release"}, bus.release_pulse, vecs[i].rl);
        end

        // Release of channel 0: the strobe lands on the 6th edge counting the sampling edge.
        bus.button_raw = 2'b11;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.release_pulse == 2'b00 && n < 20);
        check_int("hand_release_latency", n, D + 2);
        check("hand_release_db", bus.button_debounced, 2'b11);
        check("hand_release_strobe", bus.release_pulse, 2'b01);
        step();
        check("hand_release_width", bus.release_pulse, 2'b00);

        // Enable held low across a long press: level frozen, no strobes.
        bus.enable     = 1'b0;
        bus.button_raw = 2'b10;
        for (int k = 0; k < 10; k++) begin
            step();
            check("hand_en_hold_db", bus.button_debounced, 2'b11);
            check("hand_en_hold_press", bus.press_pulse, 2'b00);
        end
        // Synchronizer already holds the new level, so only the D filter samples remain.
        bus.enable = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.press_pulse == 2'b00 && n < 20);
        check_int("hand_reenable_latency", n, D);
        check("hand_reenable_db", bus.button_debounced, 2'b10);
        check("hand_reenable_strobe", bus.press_pulse, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
